// File: rtl/button_debounce.sv
// button_debounce: conditions a raw, asynchronous pushbutton pin into a clean
// debounced level plus one-cycle press/release strobes.
// Structure: SYNC_STAGES-deep synchroniser -> settle counter -> 4-state FSM.
// Optional long-press strobe is enabled by defining DEBOUNCE_LONGPRESS_EN;
// without it LONG is tied low and all other timing is identical.
module button_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_WIDTH       = 17,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 131071
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic BTN,
    output logic LEVEL,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG
);

    localparam logic [1:0] IDLE_LO   = 2'd0;
    localparam logic [1:0] SETTLE_HI = 2'd1;
    localparam logic [1:0] IDLE_HI   = 2'd2;
    localparam logic [1:0] SETTLE_LO = 2'd3;

    localparam longint CNT_MAX = (longint'(1) << CNT_WIDTH) - 1;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // Counters never wrap: both windows must fit below the all-ones value.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("button_debounce: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES) > CNT_MAX) begin : g_bad_debounce
        $error("button_debounce: DEBOUNCE_CYCLES must be in 2 .. 2**CNT_WIDTH-1");
    end
    if (LONG_CYCLES < 1 || longint'(LONG_CYCLES) > CNT_MAX) begin : g_bad_long
        $error("button_debounce: LONG_CYCLES must be in 1 .. 2**CNT_WIDTH-1");
    end

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    logic [1:0]             state;
    logic [CNT_WIDTH-1:0]   cnt;

    assign sync = sync_ff[SYNC_STAGES-1];

    // Synchronise the asynchronous button pin into the CLK domain.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], BTN};
        end
    end

    // Debounce FSM: a change is accepted only after DEBOUNCE_CYCLES stable samples.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state   <= IDLE_LO;
            cnt     <= '0;
            LEVEL   <= 1'b0;
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
        end else begin
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
            case (state)
                IDLE_LO: begin
                    if (sync) begin
                        state <= SETTLE_HI;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                SETTLE_HI: begin
                    if (!sync) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_HI;
                        LEVEL <= 1'b1;
                        PRESS <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                IDLE_HI: begin
                    if (!sync) begin
                        state <= SETTLE_LO;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                SETTLE_LO: begin
                    if (sync) begin
                        state <= IDLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= IDLE_LO;
                        LEVEL   <= 1'b0;
                        RELEASE <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(LONG_CYCLES - 1);

    logic [CNT_WIDTH-1:0] hold_cnt;
    logic                 press_accept;

    assign press_accept = (state == SETTLE_HI) && sync && (cnt == CNT_LAST);

    // Hold timer: cleared when a press is accepted, keeps counting through
    // release bounces (SETTLE_LO) and saturates, so LONG fires once per press.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            hold_cnt <= '0;
            LONG     <= 1'b0;
        end else begin
            LONG <= 1'b0;
            if (press_accept) begin
                hold_cnt <= '0;
            end else if (state == IDLE_HI || state == SETTLE_LO) begin
                if (hold_cnt != '1) begin
                    hold_cnt <= hold_cnt + CNT_ONE;
                end
                if (hold_cnt == HOLD_LAST) begin
                    LONG <= 1'b1;
                end
            end
        end
    end
`else
    assign LONG = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed testbench for button_debounce with DEBOUNCE_CYCLES=8, LONG_CYCLES=20.
// Cycle 0 is the point where BTN is changed (1 time unit after a rising edge);
// cycle n is sampled 1 time unit after the n-th following rising edge.
// Outputs are compared as the vector {LEVEL, PRESS, RELEASE, LONG}.
module tb_button_debounce;

    logic clk;
    logic resetn;
    logic btn;
    logic level;
    logic press;
    logic release_s;
    logic long_s;

    int n_checks;
    int n_fail;

    button_debounce #(
        .SYNC_STAGES    (2),
        .CNT_WIDTH      (17),
        .DEBOUNCE_CYCLES(8),
        .LONG_CYCLES    (20)
    ) dut (
        .CLK    (clk),
        .RESETN (resetn),
        .BTN    (btn),
        .LEVEL  (level),
        .PRESS  (press),
        .RELEASE(release_s),
        .LONG   (long_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        btn    = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        resetn = 1'b0;
        btn    = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            btn = (c % 3 != 0);
            step();
            obs = {level, press, release_s, long_s};
            n_checks++;
            if (obs !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset c=%0d got=%b exp=0000", c, obs);
            end
        end
        btn    = 1'b0;
        resetn = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_clean_press();
        logic [3:0] obs;
        logic [3:0] exp;
        btn = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            obs = {level, press, release_s, long_s};
            exp = {c >= 10, c == 10, 1'b0, 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL clean_press c=%0d got=%b exp=%b", c, obs, exp);
            end
        end
        btn = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            step();
            obs = {level, press, release_s, long_s};
            exp = {c < 10, 1'b0, c == 10, 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL clean_release c=%0d got=%b exp=%b", c, obs, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] obs;
        logic [3:0] exp;
        btn = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            step();
            if (c == 5) btn = 1'b0;
            if (c == 7) btn = 1'b1;
            obs = {level, press, release_s, long_s};
            exp = {c >= 17, c == 17, 1'b0, 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL bounce c=%0d got=%b exp=%b", c, obs, exp);
            end
        end
        do_reset();
    endtask

    task automatic test_glitch();
        logic [3:0] obs;
        logic [3:0] exp;
        // 7-cycle pulse: one sample short of acceptance.
        btn = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 7) btn = 1'b0;
            obs = {level, press, release_s, long_s};
            n_checks++;
            if (obs !== 4'b0000) begin
                n_fail++;
                $display("FAIL glitch7 c=%0d got=%b exp=0000", c, obs);
            end
        end
        // 8-cycle pulse: exactly long enough to be accepted, then released.
        btn = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            step();
            if (c == 8) btn = 1'b0;
            obs = {level, press, release_s, long_s};
            exp = {c >= 10 && c < 18, c == 10, c == 18, 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL pulse8 c=%0d got=%b exp=%b", c, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_settle();
        logic [3:0] obs;
        logic [3:0] exp;
        btn = 1'b1;
        repeat (6) step();
        resetn = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            obs = {level, press, release_s, long_s};
            n_checks++;
            if (obs !== 4'b0000) begin
                n_fail++;
                $display("FAIL mid_reset_hold c=%0d got=%b exp=0000", c, obs);
            end
        end
        resetn = 1'b1;
        for (int d = 1; d <= 14; d++) begin
            step();
            obs = {level, press, release_s, long_s};
            exp = {d >= 10, d == 10, 1'b0, 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL mid_reset_after d=%0d got=%b exp=%b", d, obs, exp);
            end
        end
        do_reset();
    endtask

    task automatic test_long_press();
        logic [3:0] obs;
        logic [3:0] exp;
        logic       long_exp;
        btn = 1'b1;
        for (int c = 1; c <= 56; c++) begin
            step();
            if (c == 40) btn = 1'b0;
`ifdef DEBOUNCE_LONGPRESS_EN
            long_exp = (c == 30);
`else
            long_exp = 1'b0;
`endif
            obs = {level, press, release_s, long_s};
            exp = {c >= 10 && c < 50, c == 10, c == 50, long_exp};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL long_press c=%0d got=%b exp=%b", c, obs, exp);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        btn      = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_reset_mid_settle();
        test_long_press();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
